adc_fifo_write: RTL

Write-side companion to the FIFO read stage in the ADC FIFO test path. On a start strobe it accepts a fixed number of 16-bit ADC samples over a valid/ready handshake, splits each into two bytes (MSB first) and pushes them into the byte-wide FIFO, stalling on FIFO full. When the burst is complete it raises done, so the downstream read stage can drain the FIFO.

---
 rtl/adc_fifo_write.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/adc_fifo_write.sv
// adc_fifo_write: bursts 16-bit ADC samples into a byte FIFO, MSB first.
// Define ADC_FIFO_CSUM_EN to append an XOR checksum byte per burst.
module adc_fifo_write #(
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fs,
    output logic             fd,
    output logic [2:0]       so,
    output logic             err,
    input  logic [CNT_W-1:0] sample_num,
    input  logic [15:0]      adc_data,
    input  logic             adc_valid,
    output logic             adc_ready,
    output logic [7:0]       fifo_txd,
    output logic             fifo_txen,
    input  logic             fifo_full
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_HIGH = 3'd2,
        S_LOW  = 3'd3,
        S_CSUM = 3'd4,
        S_LAST = 3'd5
    } state_t;

`ifdef ADC_FIFO_CSUM_EN
    localparam state_t S_END = S_CSUM;
`else
    localparam state_t S_END = S_LAST;
`endif

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] num_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_inc;
    logic [15:0]      sample_q;
    logic             err_q;
    logic             start;
    logic             abort;
    logic             busy;

`ifdef ADC_FIFO_CSUM_EN
    logic [7:0]       csum_q;
`endif

    assign count_inc = count_q + CNT_W'(1);
    assign start     = (state_q == S_IDLE) && fs;
    assign busy      = (state_q == S_WAIT) || (state_q == S_HIGH) ||
                       (state_q == S_LOW)  || (state_q == S_CSUM);
    // Dropping fs mid-burst abandons the burst without a write.
    assign abort     = busy && !fs;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; unknown codes fall back to IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (fs) begin
                    state_d = (sample_num == '0) ? S_END : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!fs) begin
                    state_d = S_IDLE;
                end else if (adc_valid) begin
                    state_d = S_HIGH;
                end
            end
            S_HIGH: begin
                if (!fs) begin
                    state_d = S_IDLE;
                end else if (!fifo_full) begin
                    state_d = S_LOW;
                end
            end
            S_LOW: begin
                if (!fs) begin
                    state_d = S_IDLE;
                end else if (!fifo_full) begin
                    state_d = (count_inc == num_q) ? S_END : S_WAIT;
                end
            end
`ifdef ADC_FIFO_CSUM_EN
            S_CSUM: begin
                if (!fs) begin
                    state_d = S_IDLE;
                end else if (!fifo_full) begin
                    state_d = S_LAST;
                end
            end
`endif
            S_LAST: begin
                if (!fs) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state, registered data and FIFO status.
    always_comb begin
        fifo_txd  = 8'h00;
        fifo_txen = 1'b0;
        adc_ready = 1'b0;
        fd        = 1'b0;
        unique case (state_q)
            S_WAIT: adc_ready = fs;
            S_HIGH: begin
                fifo_txd  = sample_q[15:8];
                fifo_txen = fs && !fifo_full;
            end
            S_LOW: begin
                fifo_txd  = sample_q[7:0];
                fifo_txen = fs && !fifo_full;
            end
`ifdef ADC_FIFO_CSUM_EN
            S_CSUM: begin
                fifo_txd  = csum_q;
                fifo_txen = fs && !fifo_full;
            end
`endif
            S_LAST: fd = 1'b1;
            default: fd = 1'b0;
        endcase
    end

    assign so  = state_q;
    assign err = err_q;

    // Burst bookkeeping: length latch, sample capture, count, abort flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_q    <= '0;
            count_q  <= '0;
            sample_q <= 16'h0000;
            err_q    <= 1'b0;
        end else begin
            if (start) begin
                num_q   <= sample_num;
                count_q <= '0;
                err_q   <= 1'b0;
            end
            if (abort) begin
                err_q <= 1'b1;
            end
            if (adc_ready && adc_valid) begin
                sample_q <= adc_data;
            end
            if ((state_q == S_LOW) && fifo_txen) begin
                count_q <= count_inc;
            end
        end
    end

`ifdef ADC_FIFO_CSUM_EN
    // Running XOR over every data byte written in this burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum_q <= 8'h00;
        end else if (start) begin
            csum_q <= 8'h00;
        end else if (fifo_txen && (state_q != S_CSUM)) begin
            csum_q <= csum_q ^ fifo_txd;
        end
    end
`endif

endmodule
